// File: rtl/satatrn_pkg.sv
// Shared definitions for the SATA transport receive path: FIS type codes,
// the arbiter state encoding and a header classification helper.
package satatrn_pkg;

    // FIS type codes carried in header word bits [7:0]
    localparam logic [7:0] FIS_REG_H2D      = 8'h27;
    localparam logic [7:0] FIS_REG_D2H      = 8'h34;
    localparam logic [7:0] FIS_DMA_ACT      = 8'h39;
    localparam logic [7:0] FIS_DMA_SETUP    = 8'h41;
    localparam logic [7:0] FIS_DATA         = 8'h46;
    localparam logic [7:0] FIS_BIST         = 8'h58;
    localparam logic [7:0] FIS_PIO_SETUP    = 8'h5F;
    localparam logic [7:0] FIS_SET_DEV_BITS = 8'hA1;

    // Receive arbiter states; ST_DROP is only reachable with length checking
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_REG  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // A header word opens a DATA FIS when its type byte is FIS_DATA
    function automatic logic is_data_fis(input logic [31:0] word);
        return word[7:0] == FIS_DATA;
    endfunction

endpackage

// File: rtl/satatrn_skid.sv
// Single-stage registered output for one stream. A word loaded by the
// parent appears on the outputs the following cycle; "free" tells the
// parent this stage can take a word on the current cycle.
module satatrn_skid #(
    parameter logic OPT_LOWPOWER = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        free
);

    // The stage may be overwritten when empty or when its word leaves now
    assign free = !out_valid || out_ready;

    // Output register: load a new word, or retire the current one on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            if (OPT_LOWPOWER) begin
                out_data <= 32'd0;
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/satatrn_rxarb.sv
// SATA transport receive arbiter. Splits the FIS stream from the link layer
// into a register-class stream (header included) and a DATA payload stream
// (header stripped). Optional DATA length checking is enabled by defining
// SATATRN_RXARB_LENCHK_EN.
//
// Handshake: every stream moves a word on a cycle where valid && ready are
// both high at the rising clock edge; a source holds valid/data/last stable
// until that happens, and ready may depend combinationally on valid.
module satatrn_rxarb
    import satatrn_pkg::*;
#(
    parameter logic OPT_LOWPOWER = 1'b0,
    parameter int   LGMAXLEN     = 11
) (
    input  logic        i_phy_clk,
    input  logic        i_phy_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data,
    input  logic        i_last,
    output logic        o_reg_valid,
    input  logic        i_reg_ready,
    output logic [31:0] o_reg_data,
    output logic        o_reg_last,
    output logic        o_data_valid,
    input  logic        i_data_ready,
    output logic [31:0] o_data_data,
    output logic        o_data_last,
    output logic        o_err,
    output state_t      o_dbg_state
);

    state_t state, next_state;
    logic   accept;
    logic   reg_free, data_free;
    logic   reg_load, data_load;
    logic   data_last_in;

`ifdef SATATRN_RXARB_LENCHK_EN
    logic [LGMAXLEN:0] pay_cnt;
    logic              cnt_at_max;
    logic              err_set;

    // Count already equals 2^LGMAXLEN-1: the word being accepted is the last allowed
    assign cnt_at_max = (pay_cnt == {1'b0, {LGMAXLEN{1'b1}}});
`endif

    assign accept      = i_valid && o_ready;
    assign o_dbg_state = state;

    // State register
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) state <= ST_HDR;
        else                state <= next_state;
    end

    // Next-state, upstream ready and output-stage load decisions
    always_comb begin
        next_state   = state;
        o_ready      = 1'b0;
        reg_load     = 1'b0;
        data_load    = 1'b0;
        data_last_in = i_last;
`ifdef SATATRN_RXARB_LENCHK_EN
        err_set      = 1'b0;
`endif
        case (state)
            ST_HDR: begin
                // DATA headers are swallowed, so they never wait on an output
                o_ready = is_data_fis(i_data) ? 1'b1 : reg_free;
                if (accept) begin
                    if (is_data_fis(i_data)) begin
                        if (!i_last) next_state = ST_DATA;
                    end else begin
                        reg_load = 1'b1;
                        if (!i_last) next_state = ST_REG;
                    end
                end
            end
            ST_REG: begin
                o_ready = reg_free;
                if (accept) begin
                    reg_load = 1'b1;
                    if (i_last) next_state = ST_HDR;
                end
            end
            ST_DATA: begin
                o_ready = data_free;
                if (accept) begin
                    data_load = 1'b1;
                    if (i_last) begin
                        next_state = ST_HDR;
`ifdef SATATRN_RXARB_LENCHK_EN
                    end else if (cnt_at_max) begin
                        // Truncate an oversized FIS: close it here, flag it, discard the rest
                        data_last_in = 1'b1;
                        err_set      = 1'b1;
                        next_state   = ST_DROP;
`endif
                    end
                end
            end
`ifdef SATATRN_RXARB_LENCHK_EN
            ST_DROP: begin
                o_ready = 1'b1;
                if (accept && i_last) next_state = ST_HDR;
            end
`endif
            default: next_state = ST_HDR;
        endcase
    end

`ifdef SATATRN_RXARB_LENCHK_EN
    // Payload word counter, restarted whenever a header is expected
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n)                  pay_cnt <= '0;
        else if (state == ST_HDR)            pay_cnt <= '0;
        else if (state == ST_DATA && accept) pay_cnt <= pay_cnt + 1'b1;
    end

    // Overflow pulse, aligned with the truncated last word on the data output
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) o_err <= 1'b0;
        else                o_err <= err_set;
    end
`else
    logic unused_lgmaxlen;

    assign unused_lgmaxlen = (LGMAXLEN > 0);
    assign o_err           = 1'b0;
`endif

    satatrn_skid #(
        .OPT_LOWPOWER (OPT_LOWPOWER)
    ) u_reg_out (
        .clk       (i_phy_clk),
        .rst_n     (i_phy_reset_n),
        .load      (reg_load),
        .in_data   (i_data),
        .in_last   (i_last),
        .out_ready (i_reg_ready),
        .out_valid (o_reg_valid),
        .out_data  (o_reg_data),
        .out_last  (o_reg_last),
        .free      (reg_free)
    );

    satatrn_skid #(
        .OPT_LOWPOWER (OPT_LOWPOWER)
    ) u_data_out (
        .clk       (i_phy_clk),
        .rst_n     (i_phy_reset_n),
        .load      (data_load),
        .in_data   (i_data),
        .in_last   (data_last_in),
        .out_ready (i_data_ready),
        .out_valid (o_data_valid),
        .out_data  (o_data_data),
        .out_last  (o_data_last),
        .free      (data_free)
    );

endmodule

// File: tb/tb_satatrn_rxarb.sv
// Directed bench for satatrn_rxarb with a per-stream expected queue.
// Build with SATATRN_RXARB_LENCHK_EN defined to cover DATA length overflow.
module tb_satatrn_rxarb;
    import satatrn_pkg::*;

    // ---------------- clock / reset ----------------
    logic        i_phy_clk = 1'b0;
    logic        i_phy_reset_n;
    logic        i_valid, o_ready;
    logic [31:0] i_data;
    logic        i_last;
    logic        o_reg_valid, i_reg_ready, o_reg_last;
    logic [31:0] o_reg_data;
    logic        o_data_valid, i_data_ready, o_data_last;
    logic [31:0] o_data_data;
    logic        o_err;
    state_t      dbg_state;

    always #5 i_phy_clk = ~i_phy_clk;

    satatrn_rxarb #(
        .OPT_LOWPOWER (1'b0),
        .LGMAXLEN     (2)
    ) dut (
        .i_phy_clk     (i_phy_clk),
        .i_phy_reset_n (i_phy_reset_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_last        (i_last),
        .o_reg_valid   (o_reg_valid),
        .i_reg_ready   (i_reg_ready),
        .o_reg_data    (o_reg_data),
        .o_reg_last    (o_reg_last),
        .o_data_valid  (o_data_valid),
        .i_data_ready  (i_data_ready),
        .o_data_data   (o_data_data),
        .o_data_last   (o_data_last),
        .o_err         (o_err),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int reg_pops     = 0;
    int data_pops    = 0;
    int err_pulses   = 0;
    logic [32:0] exp_reg_q[$];
    logic [32:0] exp_data_q[$];

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop and compare whenever an output word is handed off downstream
    always @(negedge i_phy_clk) begin
        if (i_phy_reset_n) begin
            if (o_err) err_pulses++;
            if (o_reg_valid && i_reg_ready) begin
                reg_pops++;
                tests_run++;
                assert (exp_reg_q.size() > 0) else begin
                    tests_failed++;
                    $error("FAIL reg_unexpected observed=%h expected=none", {o_reg_last, o_reg_data});
                end
                if (exp_reg_q.size() > 0) check("reg_word", {o_reg_last, o_reg_data}, exp_reg_q.pop_front());
            end
            if (o_data_valid && i_data_ready) begin
                data_pops++;
                tests_run++;
                assert (exp_data_q.size() > 0) else begin
                    tests_failed++;
                    $error("FAIL data_unexpected observed=%h expected=none", {o_data_last, o_data_data});
                end
                if (exp_data_q.size() > 0) check("data_word", {o_data_last, o_data_data}, exp_data_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left just after a rising edge; returns once the word is taken
    task automatic send_word(input logic [31:0] d, input logic l);
        logic acc;
        int   n;
        acc     = 1'b0;
        n       = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        while (!acc && n < 200) begin
            @(negedge i_phy_clk);
            acc = o_ready;
            @(posedge i_phy_clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        tests_run++;
        assert (acc) else begin
            tests_failed++;
            $error("FAIL accept_timeout observed=%h expected=accepted", d);
        end
    endtask

    // Whole FIS with expectations from the routing model
    task automatic send_fis(input logic [31:0] hdr, input int npay);
        logic        is_data;
        logic [31:0] w;
        logic        l;
        is_data = (hdr[7:0] == 8'h46);
        if (!is_data) exp_reg_q.push_back({npay == 0, hdr});
        send_word(hdr, npay == 0);
        for (int i = 1; i <= npay; i++) begin
            w = $urandom;
            l = (i == npay);
            if (is_data) exp_data_q.push_back({l, w});
            else         exp_reg_q.push_back({l, w});
            send_word(w, l);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_reg_q.size() + exp_data_q.size()) != 0 && n < 50) begin
            @(posedge i_phy_clk);
            #1;
            n++;
        end
        check("reg_q_empty", 33'(exp_reg_q.size()), 33'd0);
        check("data_q_empty", 33'(exp_data_q.size()), 33'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          rp, dp, ep;
        logic [31:0] w;

        i_phy_reset_n = 1'b0;
        i_valid       = 1'b0;
        i_data        = 32'd0;
        i_last        = 1'b0;
        i_reg_ready   = 1'b1;
        i_data_ready  = 1'b1;
        repeat (3) @(posedge i_phy_clk);
        #1;
        check("rst_valids", {31'd0, o_reg_valid, o_data_valid}, 33'd0);
        check("rst_reg_out", {o_reg_last, o_reg_data}, 33'd0);
        check("rst_data_out", {o_data_last, o_data_data}, 33'd0);
        check("rst_err", 33'(o_err), 33'd0);
        check("rst_state", 33'(dbg_state), 33'(ST_HDR));
        @(negedge i_phy_clk);
        i_phy_reset_n = 1'b1;
        @(posedge i_phy_clk);
        #1;

        // Reg FIS, 5 words: each word valid one cycle after acceptance
        rp = reg_pops;
        dp = data_pops;
        check("t1_idle", 33'(o_reg_valid), 33'd0);
        for (int i = 0; i < 5; i++) begin
            w = (i == 0) ? 32'h0000_0034 : $urandom;
            exp_reg_q.push_back({i == 4, w});
            send_word(w, i == 4);
            check("t1_latency", {o_reg_valid, o_reg_last, o_reg_data}, {1'b1, i == 4, w});
        end
        drain();
        check("t1_reg_count", 33'(reg_pops - rp), 33'd5);
        check("t1_data_idle", 33'(data_pops - dp), 33'd0);

        // DATA FIS, 4 payload words, header stripped
        rp = reg_pops;
        dp = data_pops;
        send_fis(32'h0000_0046, 4);
        drain();
        check("t2_data_count", 33'(data_pops - dp), 33'd4);
        check("t2_reg_idle", 33'(reg_pops - rp), 33'd0);

        // Reg FIS with downstream stall for 3 cycles after word 2
        rp = reg_pops;
        exp_reg_q.push_back({1'b0, 32'h0000_0034});
        exp_reg_q.push_back({1'b0, 32'hA1A1_0001});
        exp_reg_q.push_back({1'b0, 32'hA2A2_0002});
        exp_reg_q.push_back({1'b0, 32'hA3A3_0003});
        exp_reg_q.push_back({1'b1, 32'hA4A4_0004});
        send_word(32'h0000_0034, 1'b0);
        send_word(32'hA1A1_0001, 1'b0);
        send_word(32'hA2A2_0002, 1'b0);
        i_reg_ready = 1'b0;
        i_valid     = 1'b1;
        i_data      = 32'hA3A3_0003;
        i_last      = 1'b0;
        repeat (3) begin
            @(negedge i_phy_clk);
            check("t3_stall_ready", 33'(o_ready), 33'd0);
            check("t3_stall_hold", {o_reg_valid, o_reg_data}, {1'b1, 32'hA2A2_0002});
        end
        @(posedge i_phy_clk);
        #1;
        i_reg_ready = 1'b1;
        send_word(32'hA3A3_0003, 1'b0);
        send_word(32'hA4A4_0004, 1'b1);
        drain();
        check("t3_reg_count", 33'(reg_pops - rp), 33'd5);

        // Header-only DATA FIS then a reg FIS
        rp = reg_pops;
        dp = data_pops;
        send_word(32'h0000_0046, 1'b1);
        send_fis(32'h0000_0039, 2);
        drain();
        check("t4_data_idle", 33'(data_pops - dp), 33'd0);
        check("t4_reg_count", 33'(reg_pops - rp), 33'd3);

`ifdef SATATRN_RXARB_LENCHK_EN
        // Oversized DATA FIS: 6 payload words, limit 4
        dp = data_pops;
        ep = err_pulses;
        send_word(32'h0000_0046, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            w = $urandom;
            exp_data_q.push_back({1'b0, w});
            send_word(w, 1'b0);
        end
        w = $urandom;
        exp_data_q.push_back({1'b1, w});
        send_word(w, 1'b0);
        check("t5_err_pulse", 33'(o_err), 33'd1);
        send_word($urandom, 1'b0);
        check("t5_err_clear", 33'(o_err), 33'd0);
        check("t5_drop_state", 33'(dbg_state), 33'(ST_DROP));
        send_word($urandom, 1'b1);
        drain();
        check("t5_data_count", 33'(data_pops - dp), 33'd4);
        check("t5_err_count", 33'(err_pulses - ep), 33'd1);
        send_fis(32'h0000_0034, 2);
        send_fis(32'h0000_0046, 1);
        drain();
`else
        // Without length checking a long DATA FIS passes whole
        dp = data_pops;
        ep = err_pulses;
        send_fis(32'h0000_0046, 6);
        drain();
        check("t5_data_count", 33'(data_pops - dp), 33'd6);
        check("t5_err_none", 33'(err_pulses - ep), 33'd0);
`endif

        // Reset in the middle of a DATA FIS
        send_word(32'h0000_0046, 1'b0);
        exp_data_q.push_back({1'b0, 32'hBEEF_0001});
        send_word(32'hBEEF_0001, 1'b0);
        exp_data_q.push_back({1'b0, 32'hBEEF_0002});
        send_word(32'hBEEF_0002, 1'b0);
        i_phy_reset_n = 1'b0;
        #1;
        check("t6_valids", {31'd0, o_reg_valid, o_data_valid}, 33'd0);
        check("t6_data_out", {o_data_last, o_data_data}, 33'd0);
        check("t6_state", 33'(dbg_state), 33'(ST_HDR));
        exp_data_q.delete();
        @(negedge i_phy_clk);
        i_phy_reset_n = 1'b1;
        @(posedge i_phy_clk);
        #1;
        rp = reg_pops;
        dp = data_pops;
        exp_reg_q.push_back({1'b1, 32'hDEAD_BE34});
        send_word(32'hDEAD_BE34, 1'b1);
        drain();
        check("t6_hdr_after_rst", 33'(reg_pops - rp), 33'd1);
        check("t6_data_idle", 33'(data_pops - dp), 33'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
